// File: rtl/onchip_mem_arb_pkg.sv
// onchip_mem_arb_pkg: shared defaults and types for the on-chip RAM arbiter.
//   ADDR_W/DATA_W/BE_W/DEPTH/OOR_RDATA : default geometry and out-of-range read value
//   master_id_t                        : identifies master m0 (WiFi writer) or m1 (CPU reader)
//   mem_req_t                          : request fields muxed from the granted master
package onchip_mem_arb_pkg;

  localparam int          ADDR_W    = 16;
  localparam int          DATA_W    = 32;
  localparam int          BE_W      = DATA_W / 8;
  localparam int          DEPTH     = 50000;
  localparam logic [31:0] OOR_RDATA = 32'h0000_0000;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_t;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              write;
    logic [DATA_W-1:0] writedata;
  } mem_req_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, reset : clock and synchronous active-high reset
//   req[1:0]   : request per master (bit 0 = m0, bit 1 = m1)
//   grant[1:0] : one-hot grant, combinational from req and the last winner
// On a tie the master that did not win last time is granted. The last
// winner resets to M1 so m0 wins the first tie after reset.
module rr_arb2
  import onchip_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  master_id_t last_grant_r;
  logic [1:0] grant_s;

  // Grant decode: single requester wins outright, ties alternate
  always_comb begin
    grant_s = 2'b00;
    case (req)
      2'b01:   grant_s = 2'b01;
      2'b10:   grant_s = 2'b10;
      2'b11:   grant_s = (last_grant_r == M1) ? 2'b01 : 2'b10;
      default: grant_s = 2'b00;
    endcase
  end

  assign grant = grant_s;

  // Remember the most recent winner; unchanged in idle cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_r <= M1;
    end else if (grant_s[0]) begin
      last_grant_r <= M0;
    end else if (grant_s[1]) begin
      last_grant_r <= M1;
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: shares one single-port on-chip RAM between two
// pipelined Avalon-MM masters (m0 = WiFi packet writer, m1 = CPU/debug reader).
//   clk, reset        : single clock, synchronous active-high reset
//   mN_*              : per-master Avalon-MM slave port (address, byteenable,
//                       read, write, writedata, waitrequest, readdata, readdatavalid)
//   mem_*             : RAM pins; mem_readdata arrives one cycle after the address
//   stat_*            : access/conflict counters
// Optional feature macro: ONCHIP_MEM_ARB_STATS_EN builds saturating statistics
// counters; without it the stat ports are tied to zero.
// Addresses >= DEPTH are accepted but never reach the RAM; such reads return OOR_RDATA.
module onchip_mem_arbiter #(
  parameter int          ADDR_W    = onchip_mem_arb_pkg::ADDR_W,
  parameter int          DATA_W    = onchip_mem_arb_pkg::DATA_W,
  parameter int          DEPTH     = onchip_mem_arb_pkg::DEPTH,
  parameter logic [31:0] OOR_RDATA = onchip_mem_arb_pkg::OOR_RDATA
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  output logic                mem_reset_req,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic [31:0]         stat_grant0,
  output logic [31:0]         stat_grant1,
  output logic [31:0]         stat_conflict
);

  import onchip_mem_arb_pkg::*;

  localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH);

  logic              raw_req0_s, raw_req1_s;
  logic              req0_s, req1_s;
  logic [1:0]        grant_s;
  logic              grant_any_s;
  logic              in_range_s;
  logic              acc_rd_s;
  mem_req_t          sel_s;
  logic [ADDR_W-1:0] addr_hold_r;
  logic              rd_pend_r;
  master_id_t        rd_id_r;
  logic              rd_oor_r;
  logic [DATA_W-1:0] rdata_s;

  assign raw_req0_s = m0_read | m0_write;
  assign raw_req1_s = m1_read | m1_write;
  // Nothing is granted while reset is high, so no RAM access can start.
  assign req0_s     = raw_req0_s & ~reset;
  assign req1_s     = raw_req1_s & ~reset;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .reset (reset),
    .req   ({req1_s, req0_s}),
    .grant (grant_s)
  );

  assign grant_any_s    = |grant_s;
  assign m0_waitrequest = raw_req0_s & ~grant_s[0];
  assign m1_waitrequest = raw_req1_s & ~grant_s[1];

  // Mux the granted master's request onto the RAM side
  always_comb begin
    sel_s = '0;
    if (grant_s[1]) begin
      sel_s.address    = m1_address;
      sel_s.byteenable = m1_byteenable;
      sel_s.write      = m1_write;
      sel_s.writedata  = m1_writedata;
    end else begin
      sel_s.address    = m0_address;
      sel_s.byteenable = m0_byteenable;
      sel_s.write      = m0_write;
      sel_s.writedata  = m0_writedata;
    end
  end

  assign in_range_s     = (sel_s.address < DEPTH_L);
  // read+write together counts as a write, so it never produces read data
  assign acc_rd_s       = grant_any_s & ~sel_s.write;
  assign mem_address    = grant_any_s ? sel_s.address : addr_hold_r;
  assign mem_byteenable = sel_s.byteenable;
  assign mem_writedata  = sel_s.writedata;
  assign mem_chipselect = grant_any_s & in_range_s;
  assign mem_write      = grant_any_s & sel_s.write & in_range_s;
  assign mem_clken      = 1'b1;
  assign mem_reset_req  = reset;

  // Hold the RAM address steady across idle cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_hold_r <= '0;
    end else if (grant_any_s) begin
      addr_hold_r <= sel_s.address;
    end
  end

  // Read return pipeline: track who owns the data arriving next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_r <= 1'b0;
      rd_id_r   <= M0;
      rd_oor_r  <= 1'b0;
    end else begin
      rd_pend_r <= acc_rd_s;
      if (acc_rd_s) begin
        rd_id_r  <= grant_s[1] ? M1 : M0;
        rd_oor_r <= ~in_range_s;
      end
    end
  end

  // Returning data is shared; only the valid flag is steered. Reset drops
  // a read that is returning in the same cycle.
  assign rdata_s          = rd_oor_r ? OOR_RDATA[DATA_W-1:0] : mem_readdata;
  assign m0_readdata      = rdata_s;
  assign m1_readdata      = rdata_s;
  assign m0_readdatavalid = rd_pend_r & ~reset & (rd_id_r == M0);
  assign m1_readdatavalid = rd_pend_r & ~reset & (rd_id_r == M1);

`ifdef ONCHIP_MEM_ARB_STATS_EN
  logic [31:0] stat_grant0_r, stat_grant1_r, stat_conflict_r;

  // Saturating access and contention counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_grant0_r   <= 32'd0;
      stat_grant1_r   <= 32'd0;
      stat_conflict_r <= 32'd0;
    end else begin
      if (grant_s[0] && (stat_grant0_r != 32'hFFFF_FFFF)) begin
        stat_grant0_r <= stat_grant0_r + 32'd1;
      end
      if (grant_s[1] && (stat_grant1_r != 32'hFFFF_FFFF)) begin
        stat_grant1_r <= stat_grant1_r + 32'd1;
      end
      if (req0_s && req1_s && (stat_conflict_r != 32'hFFFF_FFFF)) begin
        stat_conflict_r <= stat_conflict_r + 32'd1;
      end
    end
  end

  assign stat_grant0   = stat_grant0_r;
  assign stat_grant1   = stat_grant1_r;
  assign stat_conflict = stat_conflict_r;
`else
  assign stat_grant0   = 32'd0;
  assign stat_grant1   = 32'd0;
  assign stat_conflict = 32'd0;
`endif

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Shares the single-port 50000x32 on-chip RAM between two Avalon-MM masters: m0 (WiFi packet writer) and m1 (CPU/debug reader).
- Each master sees a pipelined slave with waitrequest and readdatavalid. The arbiter drives the RAM's address, byteenable, chipselect, write, writedata, clken and reset_req pins.
- Round-robin grants allow one RAM access per cycle. Reads have a fixed latency of 1 cycle.
- Out-of-range addresses are trapped so they never alias into the RAM.

Parameters:
- ADDR_W, 16, address width for masters and RAM.
- DATA_W, 32, data width.
- DEPTH, 50000, number of valid words; addresses >= DEPTH are out of range.
- OOR_RDATA, 32'h0000_0000, read data returned for out-of-range reads.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- m0_address  in  ADDR_W  word address.
- m0_byteenable  in  DATA_W/8  byte lanes.
- m0_read  in  1  read request.
- m0_write  in  1  write request.
- m0_writedata  in  DATA_W  write data.
- m0_waitrequest  out  1  request not accepted this cycle.
- m0_readdata  out  DATA_W  read data.
- m0_readdatavalid  out  1  m0_readdata valid.
- m1_*  same eight ports as m0.
- mem_address  out  ADDR_W  to RAM address.
- mem_byteenable  out  DATA_W/8  to RAM byteenable.
- mem_chipselect  out  1  to RAM chipselect.
- mem_write  out  1  to RAM write.
- mem_writedata  out  DATA_W  to RAM writedata.
- mem_clken  out  1  to RAM clken; constant 1.
- mem_reset_req  out  1  to RAM reset_req; equals reset.
- mem_readdata  in  DATA_W  from RAM; valid one cycle after the address is presented.
- stat_grant0  out  32  m0 accepted-access counter.
- stat_grant1  out  32  m1 accepted-access counter.
- stat_conflict  out  32  counter of cycles in which both masters requested.

Behaviour:
- Request definitions:
  - reqN = mN_read | mN_write.
  - If mN_read and mN_write are both high, the access is treated as a write and no readdatavalid is produced.
- Grant (combinational, from last_grant register):
  - Only one master requesting: that master is granted.
  - Both requesting: grant the master != last_grant.
  - last_grant updates to the granted master on every grant.
  - last_grant resets to 1, so m0 wins the first tie.
- Handshake:
  - mN_waitrequest = reqN & ~grantN.
  - A master holds its signals while waitrequest is high.
  - An access is accepted in the cycle reqN & grantN.
  - Worst-case wait under continuous contention is 1 cycle.
- RAM drive in the grant cycle:
  - mem_address, mem_byteenable and mem_writedata are muxed from the granted master.
  - mem_chipselect = grant_any & in_range.
  - mem_write = granted write & in_range.
  - With no grant: chipselect=0, write=0, address holds its last value.
- Range check: in_range = (address < DEPTH), as an unsigned 16-bit compare.
  - Out-of-range write: accepted (waitrequest low) but never reaches the RAM.
  - Out-of-range read: accepted, and returns OOR_RDATA.
- Read return pipeline (registers rd_pend, rd_id, rd_oor):
  - Set on an accepted read.
  - Cycle T+1: mN_readdatavalid=1 for the matching id only.
  - mN_readdata = rd_oor ? OOR_RDATA : mem_readdata. The same value is broadcast to both masters; only the valid flag is per-master.
  - Back-to-back reads return every cycle, in order.
  - A write in cycle T+1 does not disturb the read returning in T+1.
- Reset (synchronous, takes effect at the next edge, including mid-operation):
  - All register-driven outputs (readdatavalid, counters) clear to 0.
  - Pending read data is discarded; no readdatavalid in the cycle after reset.
  - Requests present during reset are not granted; waitrequest stays 1 while reqN is high.
  - No RAM access is issued while reset is high.
- Readdata and readdata with valid=0 are don't-care.

Optional Feature:
- Macro: ONCHIP_MEM_ARB_STATS_EN.
- Defined:
  - stat_grant0 and stat_grant1 increment on each accepted access by their master.
  - stat_conflict increments on each cycle with req0 & req1.
  - All three saturate at 32'hFFFF_FFFF and clear on reset.
- Not defined: the three stat ports remain present, tied to 0, and no counter logic is built.

Decomposition:
- Package onchip_mem_arb_pkg holds:
  - ADDR_W, DATA_W, BE_W, DEPTH and OOR_RDATA defaults.
  - Typedef master_id_t (1 bit: M0=0, M1=1).
  - Typedef of a struct for a muxed request {address, byteenable, write, writedata}.
- Sub-module rr_arb2: 2-way round-robin with req[1:0] in, grant[1:0] out, and an internal last_grant register with an update on grant. It is instantiated once.

Test Plan:
- Single master: m0 writes 0xA5A5_0001 to addr 0x0010, then reads addr 0x0010 → waitrequest stays 0; readdatavalid on m0 one cycle after the read is accepted, with data 0xA5A5_0001; m1_readdatavalid stays 0.
- Contention: m0 and m1 read addrs 1 and 2 in the same cycle, held continuously for 6 cycles → grants alternate m0,m1,m0,…; each master waits at most 1 cycle; returned data stays in order for each id.
- Byteenable: write 0xFFFF_FFFF, then write 0x1234_5678 with byteenable 4'b0011, then read → 0xFFFF_5678.
- Boundaries:
  - Write 0xDEAD_0000 to addr 49999, then read it back → 0xDEAD_0000.
  - Write to addr 50000 → mem_chipselect stays 0.
  - Read addr 65535 → readdata = OOR_RDATA; RAM untouched.
- Reset mid-read: accept a read, assert reset the next cycle → no readdatavalid; after release, m0 wins the first tie.
- ONCHIP_MEM_ARB_STATS_EN: 10 cycles of dual contention → stat_conflict=10, stat_grant0=5, stat_grant1=5. Without the macro, all three read 0.
